fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/pcpu_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_unit.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcpu_pkg
//  Description : Shared types and constants for the pipelined-CPU front end.
//                Holds the fetch FSM state encoding, the fetch-queue entry
//                layout and the default reset PC.
//  Revision    : 1.0  initial release
// ============================================================================
package pcpu_pkg;

    // Fetch controller states. At most one memory request is in flight;
    // DROP waits out a request whose response must be thrown away.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    // One fetched instruction with its PC and fall-through PC.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_p4;
    } fetch_entry_t;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Register-based fetch queue. Head entry is read straight from
//                the storage flops, so it is a registered value. Flush empties
//                the queue and rewinds both pointers; it beats push and pop.
//  Revision    : 1.0  initial release
//
//  Parameters  : DEPTH    entries, power of two (2..16)
//                ENTRY_T  entry type
//  Ports       : clk, rst      clock, synchronous active-high reset
//                push/push_data  write an entry (ignored when full, unless
//                                a pop happens in the same cycle)
//                pop             drop head entry (ignored when empty)
//                flush           empty the queue
//                count           number of stored entries
//                head            oldest entry
// ============================================================================
module fetch_fifo
    import pcpu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  ENTRY_T                     push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output ENTRY_T                     head
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam int               CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    ENTRY_T             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop_ok;
    logic               w_push_ok;

    assign w_pop_ok  = pop && (r_count != '0);
    // A full queue can still take a push when the head leaves in the same cycle.
    assign w_push_ok = push && ((r_count != c_full) || w_pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) wide, so they wrap naturally.
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Keeps the fetch PC, issues one
//                instruction-memory request at a time and buffers responses
//                in a fetch queue for the decode stage. A redirect flushes the
//                queue, reloads the PC and discards any response in flight.
//  Revision    : 1.0  initial release
//
//  Build macro : FETCH_PERF_EN adds saturating counters perf_fetch (accepted
//                pushes) and perf_flush (redirects).
//
//  Ports       : clk, rst            clock, synchronous active-high reset
//                redirect            one-cycle taken branch/jump from ID
//                redirect_target     new PC when redirect=1
//                id_ready            ID consumes the head entry this cycle
//                if_valid            head entry valid
//                if_inst/if_pc/if_pc_p4  head instruction, its PC, PC+4
//                mem_cs/mem_addr     instruction-memory request, word address
//                mem_ack/mem_rdata   instruction-memory response
//                perf_fetch/perf_flush  (FETCH_PERF_EN only)
// ============================================================================
module fetch_unit
    import pcpu_pkg::*;
#(
    parameter int          FQ_DEPTH = 4,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [31:0]       redirect_target,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [31:0]       if_inst,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pc_p4,
    output logic              mem_cs,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_flush
`endif
);

    localparam int               CNT_W   = $clog2(FQ_DEPTH + 1);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(FQ_DEPTH);

    fetch_state_t     r_state;
    fetch_state_t     w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_p4;
    logic [CNT_W-1:0] w_count;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;
    logic             w_push;
    logic             w_pop;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // Holding off during a redirect guarantees the first request for
            // the new PC goes out no earlier than the cycle after the pulse.
            ST_IDLE: if (!redirect && (w_count < c_depth)) w_state_nxt = ST_WAIT;
            // A response coinciding with a redirect is simply discarded.
            ST_WAIT: begin
                if (mem_ack) begin
                    w_state_nxt = ST_IDLE;
                end else if (redirect) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: if (mem_ack) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_cs = 1'b0;
        w_push = 1'b0;
        w_pop  = 1'b0;
        // Request is visible only in WAIT; DROP has no live request to show.
        mem_cs = (r_state == ST_WAIT);
        // Redirect outranks both queue operations.
        w_push = (r_state == ST_WAIT) && mem_ack && !redirect;
        w_pop  = if_valid && id_ready && !redirect;
    end

    // ---------------------------------------------------------------- PC
    assign w_pc_p4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= redirect_target;
        end else if (w_push) begin
            r_pc <= w_pc_p4;
        end
    end

    assign mem_addr = r_pc[2 +: ADDR_W];

    // ---------------------------------------------------------------- queue
    assign w_push_entry = '{inst: mem_rdata, pc: r_pc, pc_p4: w_pc_p4};

    fetch_fifo #(
        .DEPTH   (FQ_DEPTH),
        .ENTRY_T (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (redirect),
        .count     (w_count),
        .head      (w_head)
    );

    assign if_valid = (w_count != '0);
    assign if_inst  = w_head.inst;
    assign if_pc    = w_head.pc;
    assign if_pc_p4 = w_head.pc_p4;

`ifdef FETCH_PERF_EN
    // ---------------------------------------------------------------- perf
    // Requests are only issued with room in the queue, so every w_push lands.
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_push && (r_perf_fetch != 32'hFFFF_FFFF)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (redirect && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_fetch = r_perf_fetch;
    assign perf_flush = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit, with a small
//                latency-programmable instruction memory model and a direct
//                check of the fetch_fifo full push+pop case.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    import pcpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_p4;
    logic        mem_cs;
    logic [9:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .FQ_DEPTH (4),
        .ADDR_W   (10),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .id_ready        (id_ready),
        .if_valid        (if_valid),
        .if_inst         (if_inst),
        .if_pc           (if_pc),
        .if_pc_p4        (if_pc_p4),
        .mem_cs          (mem_cs),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch      (perf_fetch),
        .perf_flush      (perf_flush)
`endif
    );

    // Direct instance of the queue for the full-queue push+pop case.
    logic         f_push = 1'b0;
    logic         f_pop = 1'b0;
    logic         f_flush = 1'b0;
    fetch_entry_t f_din = '0;
    logic [2:0]   f_count;
    fetch_entry_t f_head;

    fetch_fifo #(
        .DEPTH   (4),
        .ENTRY_T (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (f_push),
        .push_data (f_din),
        .pop       (f_pop),
        .flush     (f_flush),
        .count     (f_count),
        .head      (f_head)
    );

    // ------------------------------------------------ memory model
    // Latches a request when it first sees mem_cs, answers mem_lat cycles
    // later with inst = 0xA000_0000 | word address. manual_ack injects a
    // response by hand (stale-ack scenario).
    int          mem_lat = 1;
    logic        model_ack = 1'b0;
    logic [31:0] model_rdata = 32'h0;
    logic        manual_ack = 1'b0;
    logic [31:0] manual_rdata = 32'h0;
    logic        mdl_busy = 1'b0;
    int          mdl_cnt = 0;
    logic [9:0]  mdl_addr = 10'h0;

    assign mem_ack   = model_ack | manual_ack;
    assign mem_rdata = manual_ack ? manual_rdata : model_rdata;

    always @(posedge clk) begin
        #1;
        model_ack = 1'b0;
        if (rst) begin
            mdl_busy = 1'b0;
        end else if (mdl_busy) begin
            mdl_cnt = mdl_cnt - 1;
            if (mdl_cnt == 0) begin
                model_ack   = 1'b1;
                model_rdata = 32'hA000_0000 | {22'd0, mdl_addr};
                mdl_busy    = 1'b0;
            end
        end else if (mem_cs) begin
            mdl_addr = mem_addr;
            mdl_cnt  = mem_lat;
            mdl_busy = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------ helpers (no checks)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        redirect   = 1'b0;
        manual_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_new_req(output bit found);
        logic prev;
        prev  = mem_cs;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (mem_cs && !prev) found = 1'b1;
            prev = mem_cs;
        end
    endtask

    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (if_valid) found = 1'b1;
        end
    endtask

    function automatic fetch_entry_t mk(input int i);
        fetch_entry_t e;
        e.inst  = 32'hC000_0000 + 32'(i);
        e.pc    = 32'h1000 + 32'(4 * i);
        e.pc_p4 = 32'h1004 + 32'(4 * i);
        return e;
    endfunction

    // ------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (mem_cs !== 1'b0) begin n_fail++; $display("FAIL rst_mem_cs: got %b want 0", mem_cs); end
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
        n_cmp++; if (mem_addr !== 10'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 000", mem_addr); end
        n_cmp++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL rst_if_inst: got %h want 0", if_inst); end
        n_cmp++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
        n_cmp++; if (if_pc_p4 !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc_p4: got %h want 0", if_pc_p4); end
    endtask

    task automatic test_fifo_full();
        fetch_entry_t exp;
        do_reset();
        f_pop = 1'b1;
        tick();
        f_pop = 1'b0;
        n_cmp++; if (f_count !== 3'd0) begin n_fail++; $display("FAIL fifo_pop_empty: count %0d want 0", f_count); end
        for (int i = 0; i < 4; i++) begin
            f_push = 1'b1;
            f_din  = mk(i);
            tick();
        end
        f_push = 1'b0;
        n_cmp++; if (f_count !== 3'd4) begin n_fail++; $display("FAIL fifo_fill_count: got %0d want 4", f_count); end
        // Full queue, push and pop together: count must stay at 4.
        f_push = 1'b1;
        f_pop  = 1'b1;
        f_din  = mk(4);
        tick();
        f_push = 1'b0;
        f_pop  = 1'b0;
        n_cmp++; if (f_count !== 3'd4) begin n_fail++; $display("FAIL fifo_full_pushpop_count: got %0d want 4", f_count); end
        for (int i = 1; i <= 4; i++) begin
            exp = mk(i);
            n_cmp++; if (f_head !== exp) begin n_fail++; $display("FAIL fifo_wrap_order[%0d]: got %h want %h", i, f_head.pc, exp.pc); end
            f_pop = 1'b1;
            tick();
        end
        f_pop = 1'b0;
        n_cmp++; if (f_count !== 3'd0) begin n_fail++; $display("FAIL fifo_drain_count: got %0d want 0", f_count); end
        f_push = 1'b1;
        f_din  = mk(7);
        tick();
        tick();
        f_push  = 1'b0;
        f_flush = 1'b1;
        tick();
        f_flush = 1'b0;
        n_cmp++; if (f_count !== 3'd0) begin n_fail++; $display("FAIL fifo_flush_count: got %0d want 0", f_count); end
    endtask

    task automatic test_sequential();
        logic [9:0]  addrs [3];
        logic [31:0] pcs [3];
        logic [31:0] insts [3];
        logic [31:0] p4s [3];
        int   nreq, npop, first_req, first_val;
        logic prev;
        for (int i = 0; i < 3; i++) begin
            addrs[i] = '1; pcs[i] = '1; insts[i] = '1; p4s[i] = '1;
        end
        nreq = 0; npop = 0; first_req = -1; first_val = -1; prev = 1'b0;
        id_ready = 1'b1;
        mem_lat  = 1;
        do_reset();
        for (int c = 0; c < 60 && npop < 3; c++) begin
            if (mem_cs && !prev && nreq < 3) begin
                addrs[nreq] = mem_addr;
                if (first_req < 0) first_req = c;
                nreq++;
            end
            prev = mem_cs;
            if (if_valid) begin
                pcs[npop] = if_pc; insts[npop] = if_inst; p4s[npop] = if_pc_p4;
                if (first_val < 0) first_val = c;
                npop++;
            end
            tick();
        end
        n_cmp++; if (npop != 3) begin n_fail++; $display("FAIL seq_pops: got %0d want 3", npop); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (addrs[i] !== 10'(i)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, addrs[i], 10'(i)); end
            n_cmp++; if (pcs[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pcs[i], 32'(4 * i)); end
            n_cmp++; if (insts[i] !== (32'hA000_0000 + 32'(i))) begin n_fail++; $display("FAIL seq_inst[%0d]: got %h want %h", i, insts[i], 32'hA000_0000 + 32'(i)); end
            n_cmp++; if (p4s[i] !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL seq_pc_p4[%0d]: got %h want %h", i, p4s[i], 32'(4 * i + 4)); end
        end
        n_cmp++; if (first_val - first_req != 2) begin n_fail++; $display("FAIL seq_latency: got %0d want 2", first_val - first_req); end
    endtask

    task automatic test_fill_and_wrap();
        int         nreq;
        logic       prev;
        bit         ok;
        int         n;
        logic [31:0] got [6];
        id_ready = 1'b0;
        mem_lat  = 1;
        do_reset();
        nreq = 0; prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mem_cs && !prev) nreq++;
            prev = mem_cs;
            tick();
        end
        n_cmp++; if (nreq != 4) begin n_fail++; $display("FAIL fill_requests: got %0d want 4", nreq); end
        n_cmp++; if (mem_cs !== 1'b0) begin n_fail++; $display("FAIL fill_cs_idle: got %b want 0", mem_cs); end
        n_cmp++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL fill_head_pc: got %h want 0", if_pc); end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        n_cmp++; if (if_pc !== 32'h4) begin n_fail++; $display("FAIL fill_after_pop_pc: got %h want 4", if_pc); end
        wait_new_req(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL fill_resume_timeout: got none want request"); end
        n_cmp++; if (mem_addr !== 10'h004) begin n_fail++; $display("FAIL fill_resume_addr: got %h want 004", mem_addr); end
        tick();
        tick();
        // Queue is full again with its write pointer wrapped; drain in order.
        id_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) got[i] = '1;
        for (int c = 0; c < 60 && n < 6; c++) begin
            if (if_valid) begin
                got[n] = if_pc;
                n++;
            end
            tick();
        end
        id_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (got[i] !== 32'(4 + 4 * i)) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], 32'(4 + 4 * i)); end
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        id_ready = 1'b1;
        mem_lat  = 3;
        do_reset();
        wait_new_req(ok);
        n_cmp++; if (!ok || mem_addr !== 10'h0) begin n_fail++; $display("FAIL rw_first_req: got %h ok=%0d want 000", mem_addr, ok); end
        redirect        = 1'b1;
        redirect_target = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_flush_valid: got %b want 0", if_valid); end
        wait_new_req(ok);
        n_cmp++; if (!ok || mem_addr !== 10'h040) begin n_fail++; $display("FAIL rw_next_addr: got %h ok=%0d want 040", mem_addr, ok); end
        wait_valid(ok);
        n_cmp++; if (!ok || if_pc !== 32'h100) begin n_fail++; $display("FAIL rw_first_pc: got %h ok=%0d want 100", if_pc, ok); end
        n_cmp++; if (if_inst !== 32'hA000_0040) begin n_fail++; $display("FAIL rw_first_inst: got %h want a0000040", if_inst); end
        n_cmp++; if (if_pc_p4 !== 32'h104) begin n_fail++; $display("FAIL rw_first_pc_p4: got %h want 104", if_pc_p4); end
    endtask

    task automatic test_redirect_ack();
        bit ok;
        id_ready = 1'b0;
        mem_lat  = 1;
        do_reset();
        wait_new_req(ok);
        wait_new_req(ok);
        wait_new_req(ok);
        n_cmp++; if (!ok || mem_addr !== 10'h002) begin n_fail++; $display("FAIL ra_third_req: got %h ok=%0d want 002", mem_addr, ok); end
        tick();
        // This cycle carries the ack for the third request.
        n_cmp++; if (mem_cs !== 1'b1 || if_pc !== 32'h0) begin n_fail++; $display("FAIL ra_pre_state: cs=%b pc=%h want 1/0", mem_cs, if_pc); end
        redirect        = 1'b1;
        redirect_target = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL ra_flush_valid: got %b want 0", if_valid); end
        wait_new_req(ok);
        n_cmp++; if (!ok || mem_addr !== 10'h080) begin n_fail++; $display("FAIL ra_next_addr: got %h ok=%0d want 080", mem_addr, ok); end
        wait_valid(ok);
        n_cmp++; if (!ok || if_pc !== 32'h200) begin n_fail++; $display("FAIL ra_first_pc: got %h ok=%0d want 200", if_pc, ok); end
        n_cmp++; if (if_inst !== 32'hA000_0080) begin n_fail++; $display("FAIL ra_first_inst: got %h want a0000080", if_inst); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        id_ready = 1'b1;
        mem_lat  = 3;
        do_reset();
        wait_new_req(ok);
        wait_new_req(ok);
        n_cmp++; if (!ok || mem_addr !== 10'h001) begin n_fail++; $display("FAIL rm_pre_addr: got %h ok=%0d want 001", mem_addr, ok); end
        do_reset();
        n_cmp++; if (mem_cs !== 1'b0 || mem_addr !== 10'h0) begin n_fail++; $display("FAIL rm_after_rst: cs=%b addr=%h want 0/000", mem_cs, mem_addr); end
        n_cmp++; if (if_valid !== 1'b0 || if_pc !== 32'h0) begin n_fail++; $display("FAIL rm_after_rst_q: valid=%b pc=%h want 0/0", if_valid, if_pc); end
        manual_ack   = 1'b1;
        manual_rdata = 32'hDEAD_BEEF;
        tick();
        manual_ack = 1'b0;
        n_cmp++; if (mem_cs !== 1'b1 || mem_addr !== 10'h0) begin n_fail++; $display("FAIL rm_stale_ignored: cs=%b addr=%h want 1/000", mem_cs, mem_addr); end
        wait_valid(ok);
        n_cmp++; if (!ok || if_pc !== 32'h0) begin n_fail++; $display("FAIL rm_first_pc: got %h ok=%0d want 0", if_pc, ok); end
        n_cmp++; if (if_inst !== 32'hA000_0000) begin n_fail++; $display("FAIL rm_first_inst: got %h want a0000000", if_inst); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        int n;
        id_ready = 1'b0;
        mem_lat  = 1;
        do_reset();
        redirect        = 1'b1;
        redirect_target = 32'h0000_0040;
        tick();
        tick();
        redirect = 1'b0;
        id_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            if (if_valid) n++;
            if (n < 10) tick();
        end
        n_cmp++; if (perf_fetch !== 32'd10) begin n_fail++; $display("FAIL perf_fetch: got %0d want 10", perf_fetch); end
        n_cmp++; if (perf_flush !== 32'd2) begin n_fail++; $display("FAIL perf_flush: got %0d want 2", perf_flush); end
        id_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fifo_full();
        test_sequential();
        test_fill_and_wrap();
        test_redirect_wait();
        test_redirect_ack();
        test_reset_mid();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
